// File: rtl/switch_pio_read_arbiter_pkg.sv
// Shared types and constants for the switch PIO read arbiter.
package switch_pio_arb_pkg;

  localparam int unsigned PIO_DATA_W = 32;
  localparam int unsigned PIO_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ0 = 2'd0,
    REQ1 = 2'd1,
    POLL = 2'd2
  } src_sel_e;

endpackage

// File: rtl/switch_pio_read_arbiter_if.sv
// Requester, PIO slave and switch-status signals of the read arbiter.
interface switch_pio_read_arbiter_if
  import switch_pio_arb_pkg::*;
#(
  parameter int unsigned SW_W = 8
);
  logic                  req0_valid;
  logic [PIO_ADDR_W-1:0] req0_address;
  logic                  req0_ready;
  logic                  req0_rvalid;
  logic [PIO_DATA_W-1:0] req0_rdata;

  logic                  req1_valid;
  logic [PIO_ADDR_W-1:0] req1_address;
  logic                  req1_ready;
  logic                  req1_rvalid;
  logic [PIO_DATA_W-1:0] req1_rdata;

  logic [PIO_ADDR_W-1:0] pio_address;
  logic [PIO_DATA_W-1:0] pio_readdata;

  logic [SW_W-1:0]       sw_value;
  logic                  sw_changed;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_address, req1_valid, req1_address, pio_readdata,
    output req0_ready, req0_rvalid, req0_rdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output pio_address, sw_value, sw_changed
  );

  // Requesters / PIO slave side
  modport master (
    output req0_valid, req0_address, req1_valid, req1_address, pio_readdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  pio_address, sw_value, sw_changed
  );

endinterface

// File: rtl/switch_pio_read_arbiter_poll_timer.sv
// Background poll timer: free-running down-counter raising a sticky poll request.
module switch_poll_timer #(
  parameter int unsigned POLL_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic poll_accept,
  output logic poll_pending
);

  localparam logic [15:0] RELOAD = 16'(POLL_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        expire;

  // Count down, reload on zero; an expiry while a poll is already pending merges into it
  always_comb begin
    expire    = (cnt_q == '0);
    cnt_d     = expire ? RELOAD : cnt_q - 16'd1;
    pending_d = expire | (pending_q & ~poll_accept);
  end

  // Timer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= RELOAD;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign poll_pending = pending_q;

endmodule

// File: rtl/switch_pio_read_arbiter.sv
// Arbitrates two requesters and a background switch poll onto one PIO slave.
// Each read takes IDLE(accept) -> WAIT -> CAPT; results are registered per source.
module switch_pio_read_arbiter
  import switch_pio_arb_pkg::*;
#(
  parameter int unsigned POLL_CYCLES = 1000,
  parameter int unsigned SW_W        = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  switch_pio_read_arbiter_if.slave  bus
);

  arb_state_e            state_q, state_d;
  src_sel_e              src_q, src_d;
  logic [PIO_ADDR_W-1:0] pio_address_q, pio_address_d;
  logic                  last_grant_q, last_grant_d;  // 0: req0 granted last, 1: req1
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic [PIO_DATA_W-1:0] rdata0_q, rdata0_d;
  logic [PIO_DATA_W-1:0] rdata1_q, rdata1_d;
  logic [SW_W-1:0]       sw_value_q, sw_value_d;
  logic                  sw_changed_q, sw_changed_d;

  logic poll_pending;
  logic poll_accept;
  logic ready0, ready1;
  logic win0, win1;

  switch_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .poll_accept  (poll_accept),
    .poll_pending (poll_pending)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: any accept in IDLE starts the fixed three-cycle sequence
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (poll_accept || ready0 || ready1) state_d = WAIT;
      WAIT:    state_d = CAPT;
      CAPT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant outputs: pending poll first, then round-robin between requesters
  always_comb begin
    win0        = bus.req0_valid & (~bus.req1_valid | last_grant_q);
    win1        = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    poll_accept = (state_q == IDLE) & poll_pending;
    ready0      = (state_q == IDLE) & ~poll_pending & win0;
    ready1      = (state_q == IDLE) & ~poll_pending & win1;
  end

  // Datapath next values: latch grant at accept, capture read data in CAPT
  always_comb begin
    src_d         = src_q;
    pio_address_d = pio_address_q;
    last_grant_d  = last_grant_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    sw_value_d    = sw_value_q;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    sw_changed_d  = 1'b0;

    if (poll_accept) begin
      src_d         = POLL;
      pio_address_d = '0;
    end else if (ready0) begin
      src_d         = REQ0;
      pio_address_d = bus.req0_address;
      last_grant_d  = 1'b0;
    end else if (ready1) begin
      src_d         = REQ1;
      pio_address_d = bus.req1_address;
      last_grant_d  = 1'b1;
    end

    if (state_q == CAPT) begin
      unique case (src_q)
        REQ0: begin
          rdata0_d  = bus.pio_readdata;
          rvalid0_d = 1'b1;
        end
        REQ1: begin
          rdata1_d  = bus.pio_readdata;
          rvalid1_d = 1'b1;
        end
        POLL: begin
          sw_value_d   = bus.pio_readdata[SW_W-1:0];
          sw_changed_d = (bus.pio_readdata[SW_W-1:0] != sw_value_q);
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q         <= REQ0;
      pio_address_q <= '0;
      last_grant_q  <= 1'b1;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      sw_value_q    <= '0;
      sw_changed_q  <= 1'b0;
    end else begin
      src_q         <= src_d;
      pio_address_q <= pio_address_d;
      last_grant_q  <= last_grant_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      sw_value_q    <= sw_value_d;
      sw_changed_q  <= sw_changed_d;
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.req0_rvalid = rvalid0_q;
  assign bus.req1_rvalid = rvalid1_q;
  assign bus.req0_rdata  = rdata0_q;
  assign bus.req1_rdata  = rdata1_q;
  assign bus.pio_address = pio_address_q;
  assign bus.sw_value    = sw_value_q;
  assign bus.sw_changed  = sw_changed_q;

endmodule

// File: tb/tb_switch_pio_read_arbiter.sv
// Directed bench: instance A (default poll period) covers requester reads,
// round-robin and mid-read reset; instance B (8-cycle poll) covers polling.
module tb_switch_pio_read_arbiter;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       rst_b;
  logic [7:0] in_port;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  switch_pio_read_arbiter_if #(.SW_W(8)) a_if ();
  switch_pio_read_arbiter_if #(.SW_W(8)) b_if ();

  switch_pio_read_arbiter #(.SW_W(8)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (a_if)
  );

  switch_pio_read_arbiter #(.POLL_CYCLES(8), .SW_W(8)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (b_if)
  );

  // PIO slave models: registered read, switch port at address 0, zero elsewhere
  always @(posedge clk) begin
    a_if.pio_readdata <= (a_if.pio_address == 2'd0) ? {24'h0, in_port} : 32'h0;
    b_if.pio_readdata <= (b_if.pio_address == 2'd0) ? {24'h0, in_port} : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_reset_state(input string tag);
    check({tag, "_rvalid0"}, 32'(a_if.req0_rvalid), 32'd0);
    check({tag, "_rvalid1"}, 32'(a_if.req1_rvalid), 32'd0);
    check({tag, "_rdata0"},  a_if.req0_rdata, 32'd0);
    check({tag, "_rdata1"},  a_if.req1_rdata, 32'd0);
    check({tag, "_pioaddr"}, 32'(a_if.pio_address), 32'd0);
    check({tag, "_swval"},   32'(a_if.sw_value), 32'd0);
    check({tag, "_swchg"},   32'(a_if.sw_changed), 32'd0);
  endtask

  initial begin
    int sw_pulses;
    rst_a = 1'b1;
    rst_b = 1'b1;
    in_port = 8'h5A;
    a_if.req0_valid = 1'b0; a_if.req0_address = 2'd0;
    a_if.req1_valid = 1'b0; a_if.req1_address = 2'd0;
    b_if.req0_valid = 1'b0; b_if.req0_address = 2'd0;
    b_if.req1_valid = 1'b0; b_if.req1_address = 2'd0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_a_reset_state("rst");
    check("rst_b_swval", 32'(b_if.sw_value), 32'd0);

    // Single req0 read of address 0, accepted in the first cycle after reset
    next_cycle();
    rst_a = 1'b0;
    a_if.req0_valid = 1'b1;
    a_if.req0_address = 2'd0;
    @(negedge clk);
    check("r0_ready", 32'(a_if.req0_ready), 32'd1);
    check("r0_ready1_idle", 32'(a_if.req1_ready), 32'd0);
    next_cycle();
    a_if.req0_valid = 1'b0;
    @(negedge clk);
    check("r0_wait_rvalid", 32'(a_if.req0_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("r0_capt_rvalid", 32'(a_if.req0_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("r0_rvalid", 32'(a_if.req0_rvalid), 32'd1);
    check("r0_rdata", a_if.req0_rdata, 32'h0000_005A);
    next_cycle();
    @(negedge clk);
    check("r0_rvalid_pulse", 32'(a_if.req0_rvalid), 32'd0);
    check("r0_rdata_hold", a_if.req0_rdata, 32'h0000_005A);

    // Round-robin with both requesters valid continuously after reset
    rst_a = 1'b1;
    next_cycle();
    rst_a = 1'b0;
    a_if.req0_valid = 1'b1; a_if.req0_address = 2'd0;
    a_if.req1_valid = 1'b1; a_if.req1_address = 2'd0;
    for (int c = 0; c < 18; c++) begin
      int ph;
      int k;
      logic e_rdy0, e_rdy1, e_rv0, e_rv1;
      ph = c % 3;
      k  = c / 3;
      e_rdy0 = (ph == 0) && (k % 2 == 0);
      e_rdy1 = (ph == 0) && (k % 2 == 1);
      e_rv0  = (ph == 0) && (k >= 1) && ((k - 1) % 2 == 0);
      e_rv1  = (ph == 0) && (k >= 1) && ((k - 1) % 2 == 1);
      @(negedge clk);
      check($sformatf("rr_ready0_c%0d", c), 32'(a_if.req0_ready), 32'(e_rdy0));
      check($sformatf("rr_ready1_c%0d", c), 32'(a_if.req1_ready), 32'(e_rdy1));
      check($sformatf("rr_rvalid0_c%0d", c), 32'(a_if.req0_rvalid), 32'(e_rv0));
      check($sformatf("rr_rvalid1_c%0d", c), 32'(a_if.req1_rvalid), 32'(e_rv1));
      next_cycle();
    end
    a_if.req0_valid = 1'b0;
    a_if.req1_valid = 1'b0;
    @(negedge clk);
    check("rr_last_rvalid1", 32'(a_if.req1_rvalid), 32'd1);
    check("rr_rdata0", a_if.req0_rdata, 32'h0000_005A);
    check("rr_rdata1", a_if.req1_rdata, 32'h0000_005A);

    // Sole req1 read of address 2 after req1 was granted last
    next_cycle();
    a_if.req1_valid = 1'b1;
    a_if.req1_address = 2'd2;
    @(negedge clk);
    check("a2_ready1", 32'(a_if.req1_ready), 32'd1);
    next_cycle();
    a_if.req1_valid = 1'b0;
    @(negedge clk);
    check("a2_pioaddr", 32'(a_if.pio_address), 32'd2);
    next_cycle();
    @(negedge clk);
    check("a2_capt_rvalid", 32'(a_if.req1_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("a2_rvalid1", 32'(a_if.req1_rvalid), 32'd1);
    check("a2_rdata1", a_if.req1_rdata, 32'h0);

    // Reset during WAIT of a req0 read aborts it
    in_port = 8'h77;
    next_cycle();
    a_if.req0_valid = 1'b1;
    a_if.req0_address = 2'd1;
    @(negedge clk);
    check("ab_ready0", 32'(a_if.req0_ready), 32'd1);
    next_cycle();
    a_if.req0_valid = 1'b0;
    @(negedge clk);
    check("ab_wait_pioaddr", 32'(a_if.pio_address), 32'd1);
    rst_a = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("ab_rst_rvalid0_c%0d", c), 32'(a_if.req0_rvalid), 32'd0);
    end
    next_cycle();
    rst_a = 1'b0;
    @(negedge clk);
    check_a_reset_state("ab_post");
    next_cycle();
    @(negedge clk);
    check("ab_idle_rvalid0", 32'(a_if.req0_rvalid), 32'd0);
    next_cycle();
    a_if.req0_valid = 1'b1;
    a_if.req0_address = 2'd0;
    @(negedge clk);
    check("ab_re_ready0", 32'(a_if.req0_ready), 32'd1);
    next_cycle();
    a_if.req0_valid = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("ab_re_rvalid0", 32'(a_if.req0_rvalid), 32'd1);
    check("ab_re_rdata0", a_if.req0_rdata, 32'h0000_0077);

    // Polling on instance B: polls accepted in cycles 8, 16, 24, 32
    in_port = 8'h00;
    sw_pulses = 0;
    next_cycle();
    rst_b = 1'b0;
    for (int c = 0; c <= 38; c++) begin
      if (c == 12) in_port = 8'h3C;
      if (c == 32) begin
        b_if.req1_valid = 1'b1;
        b_if.req1_address = 2'd0;
      end
      if (c == 35) in_port = 8'h81;
      if (c == 36) b_if.req1_valid = 1'b0;
      @(negedge clk);
      if (c >= 12 && c <= 31 && b_if.sw_changed) sw_pulses++;
      case (c)
        11: begin
          check("p_first_swchg", 32'(b_if.sw_changed), 32'd0);
          check("p_first_swval", 32'(b_if.sw_value), 32'd0);
        end
        18: check("p_pre_swval", 32'(b_if.sw_value), 32'd0);
        19: begin
          check("p_chg_swval", 32'(b_if.sw_value), 32'h3C);
          check("p_chg_swchg", 32'(b_if.sw_changed), 32'd1);
        end
        20: check("p_chg_pulse", 32'(b_if.sw_changed), 32'd0);
        27: begin
          check("p_same_swchg", 32'(b_if.sw_changed), 32'd0);
          check("p_same_swval", 32'(b_if.sw_value), 32'h3C);
        end
        32: check("pc_ready1_poll", 32'(b_if.req1_ready), 32'd0);
        33: check("pc_ready1_wait", 32'(b_if.req1_ready), 32'd0);
        34: begin
          check("pc_ready1_capt", 32'(b_if.req1_ready), 32'd0);
          check("pc_pioaddr", 32'(b_if.pio_address), 32'd0);
        end
        35: begin
          check("pc_ready1", 32'(b_if.req1_ready), 32'd1);
          check("pc_rvalid1_poll", 32'(b_if.req1_rvalid), 32'd0);
          check("pc_rdata1_poll", b_if.req1_rdata, 32'h0);
          check("pc_swchg", 32'(b_if.sw_changed), 32'd0);
        end
        38: begin
          check("pc_rvalid1", 32'(b_if.req1_rvalid), 32'd1);
          check("pc_rdata1", b_if.req1_rdata, 32'h0000_0081);
          check("pc_swval", 32'(b_if.sw_value), 32'h3C);
          check("pc_rdata0", b_if.req0_rdata, 32'h0);
        end
        default: ;
      endcase
      next_cycle();
    end
    check("p_pulse_count", 32'(sw_pulses), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
